// File: rtl/hazard_unit_pkg.sv
// Shared types for the hazard unit slice.
//   regbits_t       : 5-bit architectural register index
//   hazard_state_t  : sequencing FSM states
//   latch_ctl_t     : flush/enable pair for each of the four pipeline latches
//   reg_match()     : destination/source compare; register 0 never matches
package hazard_unit_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    LOAD_STALL = 3'd1,
    MEM_WAIT   = 3'd2,
    REDIRECT   = 3'd3,
    HALT       = 3'd4
  } hazard_state_t;

  localparam int MAX_LOAD_BUBBLES = 3;

  // Field order is fetch/decode down to memory/writeback, flush before enable.
  typedef struct packed {
    logic fd_flush;
    logic fd_enable;
    logic de_flush;
    logic de_enable;
    logic em_flush;
    logic em_enable;
    logic mw_flush;
    logic mw_enable;
  } latch_ctl_t;

  function automatic logic reg_match(input regbits_t w, input regbits_t r);
    return (w != '0) && (w == r);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the 5-stage pipeline and the hazard unit.
//   master : pipeline side, drives latch fields and cache hits, receives hu_* requests
//   slave  : hazard unit side
// Inputs to the unit: ihit, dhit, de_rs, de_rt, de_uses_rt, ex_wsel, ex_reg_wr,
//   ex_mem_to_reg, mem_wsel, mem_reg_wr, mem_dren, mem_dwen, mem_branch_taken, mem_halt.
// Outputs: per-latch flush/enable, two conflict flags, hu_is_mem, stall_count.
interface hazard_unit_if
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic             ihit;
  logic             dhit;
  regbits_t         de_rs;
  regbits_t         de_rt;
  logic             de_uses_rt;
  regbits_t         ex_wsel;
  logic             ex_reg_wr;
  logic             ex_mem_to_reg;
  regbits_t         mem_wsel;
  logic             mem_reg_wr;
  logic             mem_dren;
  logic             mem_dwen;
  logic             mem_branch_taken;
  logic             mem_halt;

  logic             hu_fetch_decode_flush;
  logic             hu_fetch_decode_enable;
  logic             hu_decode_execute_flush;
  logic             hu_decode_execute_enable;
  logic             hu_execute_memory_flush;
  logic             hu_execute_memory_enable;
  logic             hu_memory_write_back_flush;
  logic             hu_memory_write_back_enable;
  logic             hu_decode_execute_conflict;
  logic             hu_decode_memory_conflict;
  logic             hu_is_mem;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output ihit, dhit, de_rs, de_rt, de_uses_rt, ex_wsel, ex_reg_wr, ex_mem_to_reg,
           mem_wsel, mem_reg_wr, mem_dren, mem_dwen, mem_branch_taken, mem_halt,
    input  hu_fetch_decode_flush, hu_fetch_decode_enable,
           hu_decode_execute_flush, hu_decode_execute_enable,
           hu_execute_memory_flush, hu_execute_memory_enable,
           hu_memory_write_back_flush, hu_memory_write_back_enable,
           hu_decode_execute_conflict, hu_decode_memory_conflict, hu_is_mem, stall_count
  );

  modport slave (
    input  ihit, dhit, de_rs, de_rt, de_uses_rt, ex_wsel, ex_reg_wr, ex_mem_to_reg,
           mem_wsel, mem_reg_wr, mem_dren, mem_dwen, mem_branch_taken, mem_halt,
    output hu_fetch_decode_flush, hu_fetch_decode_enable,
           hu_decode_execute_flush, hu_decode_execute_enable,
           hu_execute_memory_flush, hu_execute_memory_enable,
           hu_memory_write_back_flush, hu_memory_write_back_enable,
           hu_decode_execute_conflict, hu_decode_memory_conflict, hu_is_mem, stall_count
  );

endinterface

// File: rtl/hazard_unit_reg_match.sv
// Combinational check of whether a downstream stage writes a register the
// decode instruction reads.
//   reg_wr, wsel : downstream write enable and destination
//   rs, rt       : decode sources; rt only counts when uses_rt is set
//   conflict     : decode depends on the downstream result
module hazard_reg_match
  import hazard_unit_pkg::*;
(
  input  logic     reg_wr,
  input  regbits_t wsel,
  input  regbits_t rs,
  input  regbits_t rt,
  input  logic     uses_rt,
  output logic     conflict
);

  assign conflict = reg_wr && (reg_match(wsel, rs) || (uses_rt && reg_match(wsel, rt)));

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit: produces the hu_* flush/enable requests for the four pipeline
// latches, decode/execute and decode/memory conflict flags, hu_is_mem, and a
// saturating count of fetch/decode stall cycles (HALT cycles excluded).
//   clk, rst : clock and asynchronous active-high reset
//   hu       : slave side of hazard_unit_if (pipeline fields in, requests out)
// LOAD_BUBBLES (1..3) sets the bubbles per load-use; CNT_W sizes stall_count.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_unit_if.slave hu
);

  localparam logic [1:0] BUBBLE_INIT = 2'(LOAD_BUBBLES - 1);

  hazard_state_t    state_q, state_d;
  hazard_state_t    ret_q, ret_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [CNT_W-1:0] cnt_q;
  latch_ctl_t       ctl;
  logic             de_ex, de_mem, dmiss, load_use;

  function automatic latch_ctl_t ctl_advance(input logic en);
    latch_ctl_t c;
    c = '0;
    c.fd_enable = en;
    c.de_enable = en;
    c.em_enable = en;
    c.mw_enable = en;
    return c;
  endfunction

  // Hold fetch/decode, squash the decode/execute latch, let the load drain.
  function automatic latch_ctl_t ctl_bubble(input logic ihit);
    latch_ctl_t c;
    c = '0;
    c.de_flush  = 1'b1;
    c.em_enable = ihit;
    c.mw_enable = ihit;
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hazard_reg_match u_match_ex (
    .reg_wr(hu.ex_reg_wr), .wsel(hu.ex_wsel), .rs(hu.de_rs), .rt(hu.de_rt),
    .uses_rt(hu.de_uses_rt), .conflict(de_ex)
  );

  hazard_reg_match u_match_mem (
    .reg_wr(hu.mem_reg_wr), .wsel(hu.mem_wsel), .rs(hu.de_rs), .rt(hu.de_rt),
    .uses_rt(hu.de_uses_rt), .conflict(de_mem)
  );

  assign dmiss    = (hu.mem_dren || hu.mem_dwen) && !hu.dhit;
  assign load_use = de_ex && hu.ex_mem_to_reg;

  always_comb begin
    ctl     = ctl_advance(hu.ihit);
    state_d = state_q;
    ret_d   = ret_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      RUN: begin
        if (hu.mem_halt) begin
          ctl           = '0;
          ctl.mw_enable = 1'b1;
          state_d       = HALT;
        end else if (dmiss) begin
          ctl     = '0;
          ret_d   = RUN;
          state_d = MEM_WAIT;
        end else if (hu.mem_branch_taken) begin
          // A redirect only takes effect on a cycle the pipe actually advances.
          if (hu.ihit) begin
            ctl          = ctl_advance(1'b1);
            ctl.fd_flush = 1'b1;
            ctl.de_flush = 1'b1;
            ctl.em_flush = 1'b1;
            state_d      = REDIRECT;
          end else begin
            ctl = '0;
          end
        end else if (load_use) begin
          ctl    = ctl_bubble(hu.ihit);
          bcnt_d = BUBBLE_INIT;
          if (LOAD_BUBBLES > 1) state_d = LOAD_STALL;
        end
      end
      LOAD_STALL: begin
        if (dmiss) begin
          ctl     = '0;
          ret_d   = LOAD_STALL;
          state_d = MEM_WAIT;
        end else begin
          ctl = ctl_bubble(hu.ihit);
          if (bcnt_q <= 2'd1) begin
            bcnt_d  = '0;
            state_d = RUN;
          end else begin
            bcnt_d = bcnt_q - 2'd1;
          end
        end
      end
      MEM_WAIT: begin
        // Resume whatever sequence the miss interrupted; bubble_cnt is untouched.
        if (hu.dhit) begin
          ctl     = ctl_advance(1'b1);
          state_d = ret_q;
        end else begin
          ctl = '0;
        end
      end
      REDIRECT: begin
        if (dmiss) begin
          ctl     = '0;
          ret_d   = REDIRECT;
          state_d = MEM_WAIT;
        end else begin
          ctl.fd_flush = !hu.ihit;
          if (hu.ihit) state_d = RUN;
        end
      end
      HALT: ctl = '0;
      default: begin
        ctl     = '0;
        state_d = RUN;
      end
    endcase
    if (rst) ctl = latch_ctl_t'(8'b1010_1010);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= RUN;
      bcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      bcnt_q  <= bcnt_d;
      if (!ctl.fd_enable && state_q != HALT) cnt_q <= sat_inc(cnt_q);
    end
  end

  assign hu.hu_fetch_decode_flush       = ctl.fd_flush;
  assign hu.hu_fetch_decode_enable      = ctl.fd_enable;
  assign hu.hu_decode_execute_flush     = ctl.de_flush;
  assign hu.hu_decode_execute_enable    = ctl.de_enable;
  assign hu.hu_execute_memory_flush     = ctl.em_flush;
  assign hu.hu_execute_memory_enable    = ctl.em_enable;
  assign hu.hu_memory_write_back_flush  = ctl.mw_flush;
  assign hu.hu_memory_write_back_enable = ctl.mw_enable;
  assign hu.hu_decode_execute_conflict  = de_ex;
  assign hu.hu_decode_memory_conflict   = de_mem;
  assign hu.hu_is_mem                   = hu.mem_dren || hu.mem_dwen;
  assign hu.stall_count                 = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (LOAD_BUBBLES=1/CNT_W=32 and
// LOAD_BUBBLES=3/CNT_W=4) share one stimulus stream and are each compared
// cycle by cycle against a rule-level reference model.
module tb_hazard_unit;

  typedef struct packed {
    logic       rst, ihit, dhit;
    logic [4:0] rs, rt;
    logic       uses_rt;
    logic [4:0] ex_wsel;
    logic       ex_wr, ex_m2r;
    logic [4:0] mem_wsel;
    logic       mem_wr, dren, dwen, br, halt;
  } stim_t;

  logic  clk = 1'b0;
  logic  rst;
  stim_t cur;
  int    vecs = 0;
  int    errs = 0;

  // reference model state, index 0 -> one-bubble unit, 1 -> three-bubble unit
  bit     halted [2];
  bit     waiting[2];
  bit     redir  [2];
  int     left   [2];
  longint mcnt   [2];
  int     lb     [2] = '{1, 3};
  int     cw     [2] = '{32, 4};

  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_W(32)) if1 ();
  hazard_unit_if #(.CNT_W(4))  if3 ();

  hazard_unit #(.LOAD_BUBBLES(1), .CNT_W(32)) dut1 (.clk(clk), .rst(rst), .hu(if1.slave));
  hazard_unit #(.LOAD_BUBBLES(3), .CNT_W(4))  dut3 (.clk(clk), .rst(rst), .hu(if3.slave));

  assign rst = cur.rst;
  assign if1.ihit = cur.ihit;              assign if3.ihit = cur.ihit;
  assign if1.dhit = cur.dhit;              assign if3.dhit = cur.dhit;
  assign if1.de_rs = cur.rs;               assign if3.de_rs = cur.rs;
  assign if1.de_rt = cur.rt;               assign if3.de_rt = cur.rt;
  assign if1.de_uses_rt = cur.uses_rt;     assign if3.de_uses_rt = cur.uses_rt;
  assign if1.ex_wsel = cur.ex_wsel;        assign if3.ex_wsel = cur.ex_wsel;
  assign if1.ex_reg_wr = cur.ex_wr;        assign if3.ex_reg_wr = cur.ex_wr;
  assign if1.ex_mem_to_reg = cur.ex_m2r;   assign if3.ex_mem_to_reg = cur.ex_m2r;
  assign if1.mem_wsel = cur.mem_wsel;      assign if3.mem_wsel = cur.mem_wsel;
  assign if1.mem_reg_wr = cur.mem_wr;      assign if3.mem_reg_wr = cur.mem_wr;
  assign if1.mem_dren = cur.dren;          assign if3.mem_dren = cur.dren;
  assign if1.mem_dwen = cur.dwen;          assign if3.mem_dwen = cur.dwen;
  assign if1.mem_branch_taken = cur.br;    assign if3.mem_branch_taken = cur.br;
  assign if1.mem_halt = cur.halt;          assign if3.mem_halt = cur.halt;

  function automatic logic [10:0] obs(input int k);
    if (k == 0)
      return {if1.hu_decode_execute_conflict, if1.hu_decode_memory_conflict, if1.hu_is_mem,
              if1.hu_fetch_decode_flush, if1.hu_fetch_decode_enable,
              if1.hu_decode_execute_flush, if1.hu_decode_execute_enable,
              if1.hu_execute_memory_flush, if1.hu_execute_memory_enable,
              if1.hu_memory_write_back_flush, if1.hu_memory_write_back_enable};
    return {if3.hu_decode_execute_conflict, if3.hu_decode_memory_conflict, if3.hu_is_mem,
            if3.hu_fetch_decode_flush, if3.hu_fetch_decode_enable,
            if3.hu_decode_execute_flush, if3.hu_decode_execute_enable,
            if3.hu_execute_memory_flush, if3.hu_execute_memory_enable,
            if3.hu_memory_write_back_flush, if3.hu_memory_write_back_enable};
  endfunction

  function automatic longint cnt(input int k);
    return (k == 0) ? longint'(if1.stall_count) : longint'(if3.stall_count);
  endfunction

  function automatic logic [7:0] bubble(input logic ih);
    return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ih, 1'b0, ih};
  endfunction

  // Returns the outputs required this cycle and advances the model by one clock.
  // Latch bits: {fd_flush, fd_en, de_flush, de_en, em_flush, em_en, mw_flush, mw_en}.
  task automatic model(input int k, input stim_t v, output logic [10:0] e, output longint ec);
    logic [7:0] c;
    bit dex, dmem, miss, was_halted;
    logic ih;
    ih   = v.ihit;
    dex  = v.ex_wr && v.ex_wsel != 0 && (v.ex_wsel == v.rs || (v.uses_rt && v.ex_wsel == v.rt));
    dmem = v.mem_wr && v.mem_wsel != 0 && (v.mem_wsel == v.rs || (v.uses_rt && v.mem_wsel == v.rt));
    miss = (v.dren || v.dwen) && !v.dhit;
    ec   = v.rst ? 0 : mcnt[k];
    was_halted = halted[k];
    if (v.rst) begin
      c = 8'b1010_1010;
      halted[k] = 0; waiting[k] = 0; redir[k] = 0; left[k] = 0; mcnt[k] = 0;
    end else begin
      if (halted[k]) c = 8'b0;
      else if (waiting[k]) begin
        c = v.dhit ? 8'b0101_0101 : 8'b0;
        if (v.dhit) waiting[k] = 0;
      end else if ((left[k] > 0 || redir[k]) && miss) begin
        c = 8'b0; waiting[k] = 1;
      end else if (left[k] > 0) begin
        c = bubble(ih); left[k]--;
      end else if (redir[k]) begin
        c = {!ih, ih, 1'b0, ih, 1'b0, ih, 1'b0, ih};
        if (ih) redir[k] = 0;
      end else if (v.halt) begin
        c = 8'b0000_0001; halted[k] = 1;
      end else if (miss) begin
        c = 8'b0; waiting[k] = 1;
      end else if (v.br) begin
        c = ih ? 8'b1111_1101 : 8'b0;
        if (ih) redir[k] = 1;
      end else if (dex && v.ex_m2r) begin
        c = bubble(ih); left[k] = lb[k] - 1;
      end else c = {1'b0, ih, 1'b0, ih, 1'b0, ih, 1'b0, ih};
      if (!was_halted && !c[6] && mcnt[k] != (64'd1 << cw[k]) - 1) mcnt[k]++;
    end
    e = {dex, dmem, v.dren | v.dwen, c};
  endtask

  function automatic stim_t nop();
    stim_t s;
    s = '0; s.ihit = 1; s.dhit = 1;
    return s;
  endfunction

  function automatic stim_t with_rst();
    stim_t s;
    s = nop(); s.rst = 1;
    return s;
  endfunction

  function automatic stim_t load_use();
    stim_t s;
    s = nop(); s.ex_wsel = 3; s.ex_wr = 1; s.ex_m2r = 1; s.rs = 3; s.rt = 1; s.uses_rt = 1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst = ($urandom_range(0, 31) == 0);
    s.ihit = ($urandom_range(0, 3) != 0);
    s.dhit = ($urandom_range(0, 3) != 0);
    s.rs = 5'($urandom_range(0, 3));  s.rt = 5'($urandom_range(0, 3));
    s.uses_rt = 1'($urandom);
    s.ex_wsel = 5'($urandom_range(0, 3));  s.ex_wr = 1'($urandom);  s.ex_m2r = 1'($urandom);
    s.mem_wsel = 5'($urandom_range(0, 3)); s.mem_wr = 1'($urandom);
    s.dren = ($urandom_range(0, 3) == 0);  s.dwen = ($urandom_range(0, 7) == 0);
    s.br = ($urandom_range(0, 7) == 0);    s.halt = ($urandom_range(0, 63) == 0);
    return s;
  endfunction

  task automatic test_reset();
    stim_t q[$];
    logic [10:0] e; longint ec;
    q = '{with_rst(), with_rst(), nop(), nop()};
    foreach (q[c]) begin
      @(negedge clk); cur = q[c]; #1;
      for (int k = 0; k < 2; k++) begin
        model(k, q[c], e, ec); vecs++;
        if (obs(k) !== e) begin $display("FAIL reset dut%0d cyc%0d outs got=%b want=%b", k, c, obs(k), e); errs++; end
        if (cnt(k) !== ec) begin $display("FAIL reset_cnt dut%0d cyc%0d got=%0d want=%0d", k, c, cnt(k), ec); errs++; end
      end
    end
  endtask

  task automatic test_alu_flow();
    stim_t q[$];
    stim_t s;
    logic [10:0] e; longint ec;
    s = nop(); s.ex_wsel = 4; s.ex_wr = 1; s.rs = 1; s.rt = 2; s.uses_rt = 1; q.push_back(s);
    s = nop(); s.ex_wsel = 0; s.ex_wr = 1; s.ex_m2r = 1; s.rs = 0; q.push_back(s);
    s = nop(); s.mem_wsel = 5; s.mem_wr = 1; s.rs = 5; q.push_back(s);
    s = nop(); s.ex_wsel = 2; s.ex_wr = 1; s.ex_m2r = 1; s.rt = 2; s.rs = 1; q.push_back(s);
    s = nop(); s.ihit = 0; q.push_back(s); q.push_back(s);
    q.push_back(nop());
    foreach (q[c]) begin
      @(negedge clk); cur = q[c]; #1;
      for (int k = 0; k < 2; k++) begin
        model(k, q[c], e, ec); vecs++;
        if (obs(k) !== e) begin $display("FAIL alu_flow dut%0d cyc%0d outs got=%b want=%b", k, c, obs(k), e); errs++; end
        if (cnt(k) !== ec) begin $display("FAIL alu_cnt dut%0d cyc%0d got=%0d want=%0d", k, c, cnt(k), ec); errs++; end
      end
    end
  endtask

  task automatic test_load_use();
    stim_t q[$];
    logic [10:0] e; longint ec;
    q = '{with_rst(), load_use(), nop(), nop(), nop(), nop()};
    foreach (q[c]) begin
      @(negedge clk); cur = q[c]; #1;
      for (int k = 0; k < 2; k++) begin
        model(k, q[c], e, ec); vecs++;
        if (obs(k) !== e) begin $display("FAIL load_use dut%0d cyc%0d outs got=%b want=%b", k, c, obs(k), e); errs++; end
        if (cnt(k) !== ec) begin $display("FAIL load_use_cnt dut%0d cyc%0d got=%0d want=%0d", k, c, cnt(k), ec); errs++; end
      end
    end
  endtask

  task automatic test_mem_wait();
    stim_t q[$];
    stim_t s;
    logic [10:0] e; longint ec;
    q.push_back(with_rst());
    s = nop(); s.dren = 1; s.dhit = 0;
    repeat (4) q.push_back(s);
    s.dhit = 1; q.push_back(s);
    q.push_back(load_use());
    s = nop(); s.dwen = 1; s.dhit = 0; q.push_back(s); q.push_back(s);
    q.push_back(nop()); q.push_back(nop()); q.push_back(nop());
    foreach (q[c]) begin
      @(negedge clk); cur = q[c]; #1;
      for (int k = 0; k < 2; k++) begin
        model(k, q[c], e, ec); vecs++;
        if (obs(k) !== e) begin $display("FAIL mem_wait dut%0d cyc%0d outs got=%b want=%b", k, c, obs(k), e); errs++; end
        if (cnt(k) !== ec) begin $display("FAIL mem_wait_cnt dut%0d cyc%0d got=%0d want=%0d", k, c, cnt(k), ec); errs++; end
      end
    end
  endtask

  task automatic test_branch();
    stim_t q[$];
    stim_t s;
    logic [10:0] e; longint ec;
    q.push_back(with_rst());
    s = nop(); s.br = 1; s.ihit = 0; q.push_back(s);
    s.ihit = 1; q.push_back(s);
    s = nop(); s.ihit = 0; q.push_back(s); q.push_back(s);
    q.push_back(nop()); q.push_back(nop());
    s = nop(); s.br = 1; q.push_back(s);
    s = nop(); s.dren = 1; s.dhit = 0; s.ihit = 0; q.push_back(s);
    s.dhit = 1; q.push_back(s);
    q.push_back(nop()); q.push_back(nop());
    foreach (q[c]) begin
      @(negedge clk); cur = q[c]; #1;
      for (int k = 0; k < 2; k++) begin
        model(k, q[c], e, ec); vecs++;
        if (obs(k) !== e) begin $display("FAIL branch dut%0d cyc%0d outs got=%b want=%b", k, c, obs(k), e); errs++; end
        if (cnt(k) !== ec) begin $display("FAIL branch_cnt dut%0d cyc%0d got=%0d want=%0d", k, c, cnt(k), ec); errs++; end
      end
    end
  endtask

  task automatic test_halt();
    stim_t q[$];
    stim_t s;
    logic [10:0] e; longint ec;
    q.push_back(with_rst());
    s = load_use(); s.halt = 1; s.br = 1; q.push_back(s);
    s = nop(); s.ihit = 0; q.push_back(s);
    q.push_back(load_use()); q.push_back(nop()); q.push_back(s);
    q.push_back(with_rst()); q.push_back(nop());
    foreach (q[c]) begin
      @(negedge clk); cur = q[c]; #1;
      for (int k = 0; k < 2; k++) begin
        model(k, q[c], e, ec); vecs++;
        if (obs(k) !== e) begin $display("FAIL halt dut%0d cyc%0d outs got=%b want=%b", k, c, obs(k), e); errs++; end
        if (cnt(k) !== ec) begin $display("FAIL halt_cnt dut%0d cyc%0d got=%0d want=%0d", k, c, cnt(k), ec); errs++; end
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t q[$];
    stim_t s;
    logic [10:0] e; longint ec;
    q = '{with_rst(), load_use(), nop(), with_rst(), nop(), nop()};
    s = nop(); s.dren = 1; s.dhit = 0;
    q.push_back(s); q.push_back(s);
    s.rst = 1; q.push_back(s);
    q.push_back(nop()); q.push_back(nop());
    foreach (q[c]) begin
      @(negedge clk); cur = q[c]; #1;
      for (int k = 0; k < 2; k++) begin
        model(k, q[c], e, ec); vecs++;
        if (obs(k) !== e) begin $display("FAIL reset_mid dut%0d cyc%0d outs got=%b want=%b", k, c, obs(k), e); errs++; end
        if (cnt(k) !== ec) begin $display("FAIL reset_mid_cnt dut%0d cyc%0d got=%0d want=%0d", k, c, cnt(k), ec); errs++; end
      end
    end
  endtask

  task automatic test_saturation();
    stim_t q[$];
    stim_t s;
    logic [10:0] e; longint ec;
    q.push_back(with_rst());
    s = nop(); s.ihit = 0;
    repeat (20) q.push_back(s);
    q.push_back(nop());
    foreach (q[c]) begin
      @(negedge clk); cur = q[c]; #1;
      for (int k = 0; k < 2; k++) begin
        model(k, q[c], e, ec); vecs++;
        if (obs(k) !== e) begin $display("FAIL saturation dut%0d cyc%0d outs got=%b want=%b", k, c, obs(k), e); errs++; end
        if (cnt(k) !== ec) begin $display("FAIL saturation_cnt dut%0d cyc%0d got=%0d want=%0d", k, c, cnt(k), ec); errs++; end
      end
    end
  endtask

  task automatic test_random();
    stim_t s;
    logic [10:0] e; longint ec;
    for (int c = 0; c < 600; c++) begin
      s = (c == 0) ? with_rst() : rand_stim();
      @(negedge clk); cur = s; #1;
      for (int k = 0; k < 2; k++) begin
        model(k, s, e, ec); vecs++;
        if (obs(k) !== e) begin $display("FAIL random dut%0d cyc%0d outs got=%b want=%b", k, c, obs(k), e); errs++; end
        if (cnt(k) !== ec) begin $display("FAIL random_cnt dut%0d cyc%0d got=%0d want=%0d", k, c, cnt(k), ec); errs++; end
      end
    end
  endtask

  initial begin
    cur = with_rst();
    test_reset();
    test_alu_flow();
    test_load_use();
    test_mem_wait();
    test_branch();
    test_reset_mid();
    test_saturation();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
